// File: rtl/v_alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings, MDU FSM states and flag bundle.
// The multiply/divide unit is only built when V_ALU_MDU_EN is defined.
package v_alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_XOR   = 4'h2;
    localparam logic [3:0] ALU_OR    = 4'h3;
    localparam logic [3:0] ALU_AND   = 4'h4;
    localparam logic [3:0] ALU_SLL   = 4'h5;
    localparam logic [3:0] ALU_SRL   = 4'h6;
    localparam logic [3:0] ALU_SRA   = 4'h7;
    localparam logic [3:0] ALU_SLT   = 4'h8;
    localparam logic [3:0] ALU_SLTU  = 4'h9;
    localparam logic [3:0] ALU_MUL   = 4'hA;
    localparam logic [3:0] ALU_MULHU = 4'hB;
    localparam logic [3:0] ALU_DIV   = 4'hC;
    localparam logic [3:0] ALU_DIVU  = 4'hD;
    localparam logic [3:0] ALU_REM   = 4'hE;
    localparam logic [3:0] ALU_REMU  = 4'hF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StIter = 2'd1,
        StFix  = 2'd2
    } mdu_state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    // Opcodes A..F are the multi-cycle multiply/divide group.
    function automatic logic is_mdu_op(input logic [3:0] op);
        return op[3] & (op[2] | op[1]);
    endfunction

endpackage

// File: rtl/v_alu_mdu_iter.sv
// One-bit-per-cycle iteration datapath: shift-add multiply and restoring divide on magnitudes.
// hi/lo hold {product high, product low} or {remainder, quotient}; done rises after WIDTH steps.
module v_alu_mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] hi_q, lo_q, d_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [CNT_W-1:0] cnt_q;
    logic             div_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic             fits;

    assign done_o = (cnt_q == CNT_W'(WIDTH));
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
        rem_sh  = {hi_q, lo_q[WIDTH-1]};
        fits    = (rem_sh >= {1'b0, d_q});
        if (div_q) begin
            // Remainder stays below the divisor, so the low WIDTH bits of the difference are exact.
            hi_d = fits ? (rem_sh[WIDTH-1:0] - d_q) : rem_sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], fits};
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_q  <= '0;
            lo_q  <= '0;
            d_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= CNT_W'(WIDTH);
        end else if (start_i) begin
            hi_q  <= '0;
            lo_q  <= is_div_i ? op_a_i : op_b_i;
            d_q   <= is_div_i ? op_b_i : op_a_i;
            div_q <= is_div_i;
            cnt_q <= '0;
        end else if (!done_o) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/v_alu_pipe.sv
// Handshaked ALU with a registered output stage and an optional iterative multiply/divide unit.
// Define V_ALU_MDU_EN to build ops A-F; otherwise they complete in one cycle with result 0.
module v_alu_pipe
    import v_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v,
    output logic             busy
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    logic [WIDTH-1:0] result_q;
    alu_flags_t       flags_q;
    logic             out_valid_q;
    logic             slot_free;
    logic             accept;

    logic [WIDTH:0]   sum_ext, diff_ext;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry, alu_ovf;
    alu_flags_t       alu_flags;

    assign slot_free = ~out_valid_q | out_ready;
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign z         = flags_q.z;
    assign n         = flags_q.n;
    assign c         = flags_q.c;
    assign v         = flags_q.v;

    always_comb begin
        sum_ext   = {1'b0, a} + {1'b0, b};
        diff_ext  = {1'b0, a} - {1'b0, b};
        shamt     = b[SH_W-1:0];
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) & (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_carry = ~diff_ext[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) & (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_XOR:  alu_res = a ^ b;
            ALU_OR:   alu_res = a | b;
            ALU_AND:  alu_res = a & b;
            ALU_SLL:  alu_res = a << shamt;
            ALU_SRL:  alu_res = a >> shamt;
            ALU_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
            ALU_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
            ALU_SLTU: alu_res = WIDTH'(a < b);
            default:  alu_res = '0;
        endcase
        alu_flags.z = (alu_res == '0);
        alu_flags.n = alu_res[WIDTH-1];
        alu_flags.c = alu_carry;
        alu_flags.v = alu_ovf;
    end

`ifdef V_ALU_MDU_EN
    mdu_state_e       state_q;
    logic [3:0]       op_q;
    logic             q_neg_q, r_neg_q, b_zero_q;
    logic [WIDTH-1:0] a_q;

    logic             signed_div;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             mdu_start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_hi, iter_lo;
    logic [WIDTH-1:0] mdu_res;

    assign in_ready   = (state_q == StIdle) & slot_free & ~flush;
    assign busy       = (state_q != StIdle);
    assign signed_div = (alu_op == ALU_DIV) | (alu_op == ALU_REM);
    assign a_mag      = (signed_div & a[WIDTH-1]) ? -a : a;
    assign b_mag      = (signed_div & b[WIDTH-1]) ? -b : b;
    assign mdu_start  = accept & is_mdu_op(alu_op);

    v_alu_mdu_iter #(
        .WIDTH (WIDTH)
    ) u_mdu_iter (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (mdu_start),
        .is_div_i (alu_op[2]),
        .op_a_i   (a_mag),
        .op_b_i   (b_mag),
        .done_o   (iter_done),
        .hi_o     (iter_hi),
        .lo_o     (iter_lo)
    );

    // MIN / -1 needs no special case: |MIN| / 1 already yields MIN with a zero remainder.
    always_comb begin
        case (op_q)
            ALU_MUL:            mdu_res = iter_lo;
            ALU_MULHU:          mdu_res = iter_hi;
            ALU_DIV, ALU_DIVU:  mdu_res = b_zero_q ? '1 : (q_neg_q ? -iter_lo : iter_lo);
            ALU_REM, ALU_REMU:  mdu_res = b_zero_q ? a_q : (r_neg_q ? -iter_hi : iter_hi);
            default:            mdu_res = '0;
        endcase
    end
`else
    assign in_ready = slot_free & ~flush;
    assign busy     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            flags_q     <= '{z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b0};
            out_valid_q <= 1'b0;
`ifdef V_ALU_MDU_EN
            state_q     <= StIdle;
            op_q        <= ALU_ADD;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            b_zero_q    <= 1'b0;
            a_q         <= '0;
`endif
        end else if (flush) begin
            out_valid_q <= 1'b0;
`ifdef V_ALU_MDU_EN
            state_q     <= StIdle;
`endif
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
`ifdef V_ALU_MDU_EN
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (is_mdu_op(alu_op)) begin
                            state_q  <= StIter;
                            op_q     <= alu_op;
                            q_neg_q  <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_neg_q  <= signed_div & a[WIDTH-1];
                            b_zero_q <= (b == '0);
                            a_q      <= a;
                        end else begin
                            result_q    <= alu_res;
                            flags_q     <= alu_flags;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                StIter: begin
                    if (iter_done) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    // Wait here while the previous result is still unclaimed.
                    if (slot_free) begin
                        result_q    <= mdu_res;
                        flags_q     <= '{z: (mdu_res == '0), n: mdu_res[WIDTH-1],
                                         c: 1'b0, v: 1'b0};
                        out_valid_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
`else
            if (accept) begin
                result_q    <= alu_res;
                flags_q     <= alu_flags;
                out_valid_q <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_v_alu_pipe.sv
// Directed self-checking bench for v_alu_pipe (WIDTH=32).
// Exercises the MDU scenarios when V_ALU_MDU_EN is defined, the 1-cycle fallback otherwise.
module tb_v_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic [3:0]  alu_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        z, n, c, v;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    v_alu_pipe #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .z         (z),
        .n         (n),
        .c         (c),
        .v         (v),
        .busy      (busy)
    );

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; alu_op = 4'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if ({z, n, c, v} !== 4'b1000) begin failures++; $display("FAIL reset_flags got=%b exp=1000", {z, n, c, v}); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_arith();
        alu_op = 4'h0; a = 32'h7FFF_FFFF; b = 32'h1; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        checks++; if (result !== 32'h8000_0000) begin failures++; $display("FAIL add_result got=%h exp=80000000", result); end
        checks++; if ({z, n, c, v} !== 4'b0101) begin failures++; $display("FAIL add_flags got=%b exp=0101", {z, n, c, v}); end
        alu_op = 4'h1; a = 32'h5; b = 32'h5; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL sub_result got=%h exp=0", result); end
        checks++; if ({z, n, c, v} !== 4'b1010) begin failures++; $display("FAIL sub_flags got=%b exp=1010", {z, n, c, v}); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        alu_op = 4'h5; a = 32'h1; b = 32'd31; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || result !== 32'h8000_0000) begin failures++; $display("FAIL b2b_sll got=%b/%h exp=1/80000000", out_valid, result); end
        alu_op = 4'h7; a = 32'h8000_0000; b = 32'd4;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || result !== 32'hF800_0000) begin failures++; $display("FAIL b2b_sra got=%b/%h exp=1/f8000000", out_valid, result); end
        alu_op = 4'h9; a = 32'h1; b = 32'hFFFF_FFFF;
        @(posedge clk); #1 in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 32'h1) begin failures++; $display("FAIL b2b_sltu got=%b/%h exp=1/1", out_valid, result); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

`ifdef V_ALU_MDU_EN
    // Drives one op and waits (bounded) for its result; lat = edges after the accept edge, -1 on timeout.
    task automatic run_mdu(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                           output int lat, output logic [31:0] res);
        alu_op = op; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
        res = result;
    endtask

    task automatic test_div();
        int lat;
        logic [31:0] res;
        out_ready = 1'b1;
        run_mdu(4'hC, 32'hFFFF_FFF9, 32'h2, lat, res);
        checks++; if (lat !== 34) begin failures++; $display("FAIL div_latency got=%0d exp=34", lat); end
        checks++; if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg got=%h exp=fffffffd", res); end
        run_mdu(4'hE, 32'hFFFF_FFF9, 32'h2, lat, res);
        checks++; if (res !== 32'hFFFF_FFFF || lat !== 34) begin failures++; $display("FAIL rem_neg got=%h/%0d exp=ffffffff/34", res, lat); end
        run_mdu(4'hD, 32'h9, 32'h0, lat, res);
        checks++; if (res !== 32'hFFFF_FFFF || lat !== 34) begin failures++; $display("FAIL divu_zero got=%h/%0d exp=ffffffff/34", res, lat); end
        run_mdu(4'hF, 32'h9, 32'h0, lat, res);
        checks++; if (res !== 32'h9) begin failures++; $display("FAIL remu_zero got=%h exp=9", res); end
        run_mdu(4'hC, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
        checks++; if (res !== 32'h8000_0000 || lat !== 34) begin failures++; $display("FAIL div_ovf got=%h/%0d exp=80000000/34", res, lat); end
        run_mdu(4'hD, 32'd100, 32'd7, lat, res);
        checks++; if (res !== 32'd14) begin failures++; $display("FAIL divu_basic got=%h exp=e", res); end
    endtask

    task automatic test_mul_hold();
        int lat;
        logic [31:0] res;
        out_ready = 1'b1;
        run_mdu(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res);
        checks++; if (res !== 32'hFFFF_FFFE || lat !== 34) begin failures++; $display("FAIL mulhu got=%h/%0d exp=fffffffe/34", res, lat); end
        @(posedge clk); #1 out_ready = 1'b0;
        run_mdu(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res);
        checks++; if (res !== 32'h1 || lat !== 34) begin failures++; $display("FAIL mul got=%h/%0d exp=1/34", res, lat); end
        alu_op = 4'h0; a = 32'd2; b = 32'd2; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || result !== 32'h1 || in_ready !== 1'b0) begin failures++; $display("FAIL hold_cycle%0d got=%b/%h/%b exp=1/1/0", i, out_valid, result, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1 in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 32'd4) begin failures++; $display("FAIL hold_next got=%b/%h exp=1/4", out_valid, result); end
    endtask

    task automatic test_flush();
        logic seen;
        out_ready = 1'b1;
        alu_op = 4'hC; a = 32'd100; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b/%b exp=1/0", busy, in_ready); end
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1 flush = 1'b0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_abort got=%b/%b/%b exp=0/0/1", busy, out_valid, in_ready); end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_result got=%b exp=0", seen); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [31:0] res;
        out_ready = 1'b1;
        run_mdu(4'hA, 32'd6, 32'd7, lat, res);
        checks++; if (res !== 32'd42) begin failures++; $display("FAIL mul_small got=%h exp=2a", res); end
        alu_op = 4'hA; a = 32'd3; b = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_ctrl got=%b/%b exp=0/0", busy, out_valid); end
        checks++; if (result !== 32'h0 || {z, n, c, v} !== 4'b1000) begin failures++; $display("FAIL rst_mid_data got=%h/%b exp=0/1000", result, {z, n, c, v}); end
        @(posedge clk); #1 rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready); end
        run_mdu(4'hA, 32'd3, 32'd4, lat, res);
        checks++; if (res !== 32'd12 || lat !== 34) begin failures++; $display("FAIL mul_after_rst got=%h/%0d exp=c/34", res, lat); end
    endtask
`else
    task automatic test_no_mdu();
        logic seen_busy;
        out_ready = 1'b1;
        seen_busy = 1'b0;
        alu_op = 4'hA; a = 32'd3; b = 32'd4; in_valid = 1'b1;
        #1 if (busy === 1'b1) seen_busy = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        if (busy === 1'b1) seen_busy = 1'b1;
        checks++; if (out_valid !== 1'b1 || result !== 32'h0) begin failures++; $display("FAIL nomdu_mul got=%b/%h exp=1/0", out_valid, result); end
        checks++; if ({z, n, c, v} !== 4'b1000) begin failures++; $display("FAIL nomdu_flags got=%b exp=1000", {z, n, c, v}); end
        alu_op = 4'hD; a = 32'd9; b = 32'd0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        if (busy === 1'b1) seen_busy = 1'b1;
        checks++; if (out_valid !== 1'b1 || result !== 32'h0) begin failures++; $display("FAIL nomdu_divu got=%b/%h exp=1/0", out_valid, result); end
        checks++; if (seen_busy !== 1'b0) begin failures++; $display("FAIL nomdu_busy got=%b exp=0", seen_busy); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
`ifdef V_ALU_MDU_EN
        test_div();
        test_mul_hold();
        test_flush();
        test_reset_mid();
`else
        test_no_mdu();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
